// File: rtl/pin_responder.sv
// pin_responder: command-bus slave that drives one FPGA pin.
//
// Decodes writes addressed to BASE_ADDR into a small register file
// (END_TIME, HIGH_CYC, LOW_CYC, CMD). Writing CMD starts a pin operation:
// idle (high-Z), constant level, square wave, or explicit high-Z hold.
// An optional stop time against the global timer returns the pin to idle.
//
// Ports:
//   clk, rst       system clock; asynchronous active-high reset
//   current_time   global timer, compared against END_TIME
//   cmd_bus_addr   [15:8] unit select, [7:0] register offset
//   cmd_bus_data   write data
//   cmd_bus_en     bus cycle valid
//   cmd_bus_rd     read strobe (no read path, ignored)
//   cmd_bus_wr     write strobe
//   pin_out        pin drive value
//   pin_oe         pin output enable (1 = driven, 0 = high-Z)
//   busy           timed operation (END_TIME != 0) in progress
module pin_responder #(
  parameter logic [7:0] BASE_ADDR = 8'h01,
  parameter logic       RST_LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] current_time,
  input  logic [15:0] cmd_bus_addr,
  input  logic [31:0] cmd_bus_data,
  input  logic        cmd_bus_en,
  input  logic        cmd_bus_rd,
  input  logic        cmd_bus_wr,
  output logic        pin_out,
  output logic        pin_oe,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONST = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  localparam logic [7:0] OFF_CMD  = 8'h00;
  localparam logic [7:0] OFF_END  = 8'h01;
  localparam logic [7:0] OFF_HIGH = 8'h02;
  localparam logic [7:0] OFF_LOW  = 8'h03;

  // Phase counter reload: a programmed count of 0 behaves as 1 so every
  // phase lasts at least one cycle.
  function automatic logic [31:0] phase_load(input logic [31:0] count);
    return (count == 32'd0) ? 32'd0 : count - 32'd1;
  endfunction

  logic        hit;
  logic        hit_q;
  logic        vld_p0;
  logic [7:0]  off_p0;
  logic [31:0] data_p0;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [1:0]  mode, mode_n;
  logic [31:0] end_time, end_time_n;
  logic [31:0] high_cyc, high_cyc_n;
  logic [31:0] low_cyc, low_cyc_n;
  logic        pin_out_n, pin_oe_n, busy_n;
  logic        cmd_write;
  logic        expired;

  // No read path exists; the strobe is accepted on the port but unused.
  logic unused_rd;
  assign unused_rd = cmd_bus_rd;

  assign hit = cmd_bus_en & cmd_bus_wr & (cmd_bus_addr[15:8] == BASE_ADDR);

  // Stage p0: the scheduler holds each write for several cycles; only the
  // rising edge of hit is captured, so a held write acts exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q   <= 1'b0;
      vld_p0  <= 1'b0;
      off_p0  <= 8'd0;
      data_p0 <= 32'd0;
    end else begin
      hit_q   <= hit;
      vld_p0  <= hit & ~hit_q;
      off_p0  <= cmd_bus_addr[7:0];
      data_p0 <= cmd_bus_data;
    end
  end

  // Stage p1: register file update, pin state machine, registered outputs.
  assign cmd_write = vld_p0 && (off_p0 == OFF_CMD);
  assign expired   = (state != IDLE) && (end_time != 32'd0) &&
                     (current_time >= end_time);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    mode_n     = mode;
    end_time_n = end_time;
    high_cyc_n = high_cyc;
    low_cyc_n  = low_cyc;
    pin_out_n  = pin_out;
    pin_oe_n   = pin_oe;

    // A CMD write takes priority over stop-time expiry and restarts the
    // operation from scratch, reloading the phase counter.
    if (cmd_write) begin
      mode_n = data_p0[1:0];
      unique case (data_p0[1:0])
        2'd0: begin
          state_n   = IDLE;
          pin_oe_n  = 1'b0;
          pin_out_n = RST_LEVEL;
        end
        2'd1: begin
          state_n   = CONST;
          pin_oe_n  = 1'b1;
          pin_out_n = data_p0[2];
        end
        2'd2: begin
          state_n   = HIGH;
          pin_oe_n  = 1'b1;
          pin_out_n = 1'b1;
          cnt_n     = phase_load(high_cyc);
        end
        default: begin
          // Explicit high-Z hold: not idle, so a stop time still applies.
          state_n   = CONST;
          pin_oe_n  = 1'b0;
          pin_out_n = RST_LEVEL;
        end
      endcase
    end else if (expired) begin
      state_n   = IDLE;
      pin_oe_n  = 1'b0;
      pin_out_n = RST_LEVEL;
    end else begin
      unique case (state)
        HIGH: begin
          if (cnt == 32'd0) begin
            state_n   = LOW;
            pin_out_n = 1'b0;
            cnt_n     = phase_load(low_cyc);
          end else begin
            cnt_n = cnt - 32'd1;
          end
        end
        LOW: begin
          if (cnt == 32'd0) begin
            state_n   = HIGH;
            pin_out_n = 1'b1;
            cnt_n     = phase_load(high_cyc);
          end else begin
            cnt_n = cnt - 32'd1;
          end
        end
        default: ;
      endcase
    end

    // Count registers are only consulted at a phase reload, so mid-wave
    // writes take effect at the next phase boundary.
    if (vld_p0) begin
      unique case (off_p0)
        OFF_END:  end_time_n = data_p0;
        OFF_HIGH: high_cyc_n = data_p0;
        OFF_LOW:  low_cyc_n  = data_p0;
        default:  ;
      endcase
    end

    // Derived from next-state values so busy falls on the same edge as pin_oe.
    busy_n = (state_n != IDLE) && (end_time_n != 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 32'd0;
      mode     <= 2'd0;
      end_time <= 32'd0;
      high_cyc <= 32'd0;
      low_cyc  <= 32'd0;
      pin_out  <= RST_LEVEL;
      pin_oe   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      mode     <= mode_n;
      end_time <= end_time_n;
      high_cyc <= high_cyc_n;
      low_cyc  <= low_cyc_n;
      pin_out  <= pin_out_n;
      pin_oe   <= pin_oe_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_pin_responder.sv
// Testbench for pin_responder: directed scenarios with literal expectations,
// then randomized bus traffic, all checked every cycle against a behavioural
// model of the pin that tracks level, remaining phase cycles and stop time.
module tb_pin_responder;

  localparam logic [7:0] BASE = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tm = 32'd0;
  logic [15:0] addr = 16'd0;
  logic [31:0] data = 32'd0;
  logic        en = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        pin_out, pin_oe, busy;

  int errs = 0;
  int checks = 0;
  bit tm_auto = 1'b0;

  pin_responder #(.BASE_ADDR(BASE), .RST_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .current_time(tm),
    .cmd_bus_addr(addr), .cmd_bus_data(data),
    .cmd_bus_en(en), .cmd_bus_rd(rd), .cmd_bus_wr(wr),
    .pin_out(pin_out), .pin_oe(pin_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_st: 0 idle, 1 steady (constant or held high-Z), 2 square wave.
  logic        m_prev_hit, m_pend;
  logic [7:0]  m_poff;
  logic [31:0] m_pdata, m_end, m_high, m_low, m_left;
  int          m_st;
  logic        m_out, m_oe, m_busy;

  function automatic logic [31:0] atleast1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  task automatic model_step();
    logic hit;
    hit = en && wr && (addr[15:8] == BASE);
    if (rst) begin
      m_prev_hit = 1'b0; m_pend = 1'b0; m_poff = 8'd0; m_pdata = 32'd0;
      m_end = 32'd0; m_high = 32'd0; m_low = 32'd0; m_left = 32'd0;
      m_st = 0; m_out = 1'b0; m_oe = 1'b0; m_busy = 1'b0;
      return;
    end
    if (m_pend && m_poff == 8'd0) begin
      case (m_pdata[1:0])
        2'd0: begin m_st = 0; m_oe = 1'b0; m_out = 1'b0; end
        2'd1: begin m_st = 1; m_oe = 1'b1; m_out = m_pdata[2]; end
        2'd2: begin m_st = 2; m_oe = 1'b1; m_out = 1'b1; m_left = atleast1(m_high); end
        default: begin m_st = 1; m_oe = 1'b0; m_out = 1'b0; end
      endcase
    end else if (m_st != 0 && m_end != 32'd0 && tm >= m_end) begin
      m_st = 0; m_oe = 1'b0; m_out = 1'b0;
    end else if (m_st == 2) begin
      m_left = m_left - 32'd1;
      if (m_left == 32'd0) begin
        m_out  = !m_out;
        m_left = m_out ? atleast1(m_high) : atleast1(m_low);
      end
    end
    if (m_pend) begin
      case (m_poff)
        8'd1: m_end  = m_pdata;
        8'd2: m_high = m_pdata;
        8'd3: m_low  = m_pdata;
        default: ;
      endcase
    end
    m_busy     = (m_st != 0) && (m_end != 32'd0);
    m_pend     = hit && !m_prev_hit;
    m_poff     = addr[7:0];
    m_pdata    = data;
    m_prev_hit = hit;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("pin_out", {31'd0, pin_out}, {31'd0, m_out});
      check("pin_oe",  {31'd0, pin_oe},  {31'd0, m_oe});
      check("busy",    {31'd0, busy},    {31'd0, m_busy});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    if (tm_auto) tm = tm + 32'd1;
  endtask

  task automatic bus_write(input logic [7:0] unit, input logic [7:0] off,
                           input logic [31:0] d, input bit w, input bit r, input int hold);
    cyc();
    en = 1'b1; wr = w; rd = r; addr = {unit, off}; data = d;
    repeat (hold) cyc();
    en = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    logic [9:0]  seq;
    logic [5:0]  seq6;
    int          r;
    logic [7:0]  off;
    logic [31:0] d;

    // Reset held with a matching CMD (constant high) on the bus.
    en = 1'b1; wr = 1'b1; addr = {BASE, 8'h00}; data = 32'h5;
    idle(3);
    check("rst_oe", {31'd0, pin_oe}, 32'd0);
    check("rst_out", {31'd0, pin_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(2);
    en = 1'b0; wr = 1'b0;
    cyc();
    check("post_rst_oe", {31'd0, pin_oe}, 32'd1);
    check("post_rst_out", {31'd0, pin_out}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Square wave 3 high / 2 low, no stop time.
    bus_write(BASE, 8'h02, 32'd3, 1, 0, 2);
    bus_write(BASE, 8'h03, 32'd2, 1, 0, 2);
    bus_write(BASE, 8'h01, 32'd0, 1, 0, 2);
    bus_write(BASE, 8'h00, 32'd2, 1, 0, 2);
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      seq = {seq[8:0], pin_out};
      cyc();
    end
    check("wave_3_2", {22'd0, seq}, {22'd0, 10'b1110011100});
    check("wave_busy", {31'd0, busy}, 32'd0);

    // Constant high with stop time 100.
    tm = 32'd50;
    bus_write(BASE, 8'h01, 32'd100, 1, 0, 2);
    bus_write(BASE, 8'h00, 32'd5, 1, 0, 2);
    check("const_oe", {31'd0, pin_oe}, 32'd1);
    check("const_out", {31'd0, pin_out}, 32'd1);
    check("const_busy", {31'd0, busy}, 32'd1);
    tm = 32'd99;
    cyc();
    check("pre_stop_oe", {31'd0, pin_oe}, 32'd1);
    check("pre_stop_busy", {31'd0, busy}, 32'd1);
    tm = 32'd100;
    cyc();
    check("stop_oe", {31'd0, pin_oe}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);

    // Zero counts clamp to a period-2 wave.
    bus_write(BASE, 8'h01, 32'd0, 1, 0, 2);
    bus_write(BASE, 8'h02, 32'd0, 1, 0, 2);
    bus_write(BASE, 8'h03, 32'd0, 1, 0, 2);
    bus_write(BASE, 8'h00, 32'd2, 1, 0, 2);
    seq6 = '0;
    for (int i = 0; i < 6; i++) begin
      seq6 = {seq6[4:0], pin_out};
      cyc();
    end
    check("wave_0_0", {26'd0, seq6}, {26'd0, 6'b101010});

    // CMD=3 during a running timed wave: high-Z hold, still busy.
    bus_write(BASE, 8'h02, 32'd3, 1, 0, 2);
    bus_write(BASE, 8'h03, 32'd3, 1, 0, 2);
    bus_write(BASE, 8'h01, 32'd1000, 1, 0, 2);
    bus_write(BASE, 8'h00, 32'd2, 1, 0, 2);
    idle(3);
    bus_write(BASE, 8'h00, 32'd3, 1, 0, 2);
    check("hiz_oe", {31'd0, pin_oe}, 32'd0);
    check("hiz_out", {31'd0, pin_out}, 32'd0);
    check("hiz_busy", {31'd0, busy}, 32'd1);
    idle(4);
    check("hiz_hold_oe", {31'd0, pin_oe}, 32'd0);
    check("hiz_hold_busy", {31'd0, busy}, 32'd1);

    // CMD=2 landing on the stop-time cycle: CMD wins.
    bus_write(BASE, 8'h00, 32'd1, 1, 0, 2);
    cyc();
    tm = 32'd999; en = 1'b1; wr = 1'b1; addr = {BASE, 8'h00}; data = 32'd2;
    cyc();
    tm = 32'd1000;
    cyc();
    en = 1'b0; wr = 1'b0; tm = 32'd500;
    check("race_oe", {31'd0, pin_oe}, 32'd1);
    check("race_out", {31'd0, pin_out}, 32'd1);
    check("race_busy", {31'd0, busy}, 32'd1);
    cyc();
    check("race_oe2", {31'd0, pin_oe}, 32'd1);
    check("race_busy2", {31'd0, busy}, 32'd1);

    // Other unit and read-only cycles must not start anything.
    bus_write(BASE, 8'h00, 32'd0, 1, 0, 2);
    bus_write(BASE, 8'h01, 32'd0, 1, 0, 2);
    bus_write(BASE + 8'd1, 8'h00, 32'd5, 1, 0, 2);
    idle(2);
    check("other_unit_oe", {31'd0, pin_oe}, 32'd0);
    bus_write(BASE, 8'h00, 32'd5, 0, 1, 2);
    idle(2);
    check("rd_only_oe", {31'd0, pin_oe}, 32'd0);
    check("rd_only_out", {31'd0, pin_out}, 32'd0);

    // Randomized traffic against the model.
    tm_auto = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 4) begin
        bus_write(BASE, 8'h00, $urandom, 1, 0, 2);
      end else if (r < 10) begin
        off = 8'($urandom_range(1, 3));
        if (off == 8'd1)
          d = ($urandom_range(0, 2) == 0) ? 32'd0 : tm + 32'($urandom_range(0, 60)) - 32'd10;
        else
          d = 32'($urandom_range(0, 5));
        bus_write(BASE, off, d, 1, 0, 2);
      end else if (r == 10) begin
        bus_write(BASE + 8'($urandom_range(1, 200)), 8'($urandom_range(0, 3)), $urandom, 1, 0, 2);
      end else if (r == 11) begin
        bus_write(BASE, 8'($urandom_range(0, 3)), $urandom, 0, 1, 2);
      end else if (r == 12) begin
        bus_write(BASE, 8'($urandom_range(4, 255)), $urandom, 1, 0, 2);
      end else if (r == 13) begin
        bus_write(BASE, 8'($urandom_range(0, 3)), $urandom_range(0, 7), 1, 0,
                  int'($urandom_range(1, 4)));
      end else if (r < 18) begin
        idle(int'($urandom_range(0, 12)));
      end else if (r == 18) begin
        cyc();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
      end else begin
        tm = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 : $urandom;
      end
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pin_responder.md
Name: pin_responder

Overview:
- Slave endpoint on the internal command bus driven by the command scheduler.
- Decodes writes addressed to its base address into a small register file.
- Drives one FPGA pin as constant-low, constant-high, square wave, or high-Z, with an optional stop time referenced to the global timer.
- Exports a busy flag that the scheduler's unit-busy path consumes.

Parameters:
BASE_ADDR, 8'h01, value of cmd_bus_addr[15:8] that selects this instance
RST_LEVEL, 1'b0, pin_out value at reset and in IDLE

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
current_time  input  32  global timer value
cmd_bus_addr  input  16  [15:8] unit select, [7:0] register offset
cmd_bus_data  input  32  write data
cmd_bus_en  input  1  bus cycle valid
cmd_bus_rd  input  1  read strobe (ignored; no read path)
cmd_bus_wr  input  1  write strobe
pin_out  output  1  pin drive value
pin_oe  output  1  pin output enable (1 = driven, 0 = high-Z)
busy  output  1  timed operation in progress

Behaviour:
- Reset: async on rst high. Effects:
  - pin_out=RST_LEVEL, pin_oe=0, busy=0, state=IDLE.
  - END_TIME, HIGH_CYC and LOW_CYC = 0; mode=0; internal counter=0; edge tracker=0.
- Write accept: hit = en & wr & (addr[15:8]==BASE_ADDR).
  - The scheduler holds each write for 2 consecutive cycles. Only the first hit cycle is acted on (hit & ~hit_q, where hit_q is the registered hit).
  - Held cycles and repeated identical cycles are ignored until hit deasserts.
  - A hit with rd=1 and wr=0 is ignored.
- Registers, written on the accept edge and effective the next cycle:
  - 0x01 END_TIME[31:0]
  - 0x02 HIGH_CYC[31:0]
  - 0x03 LOW_CYC[31:0]
  - 0x00 CMD: data[1:0] = mode. Writing CMD starts the operation.
  - Any other offset: no effect.
- States: IDLE, CONST, HIGH, LOW.
- CMD write, next state by mode:
  - mode 0 -> IDLE: pin_oe=0, pin_out=RST_LEVEL.
  - mode 1 -> CONST: pin_oe=1, pin_out=data[2].
  - mode 2 -> HIGH: pin_oe=1, pin_out=1; counter loaded with max(HIGH_CYC,1)-1.
  - mode 3 -> CONST: pin_oe=0 (explicit high-Z hold; pin_out=RST_LEVEL).
- Outputs are registered. Pin changes 1 cycle after the accept edge, i.e. 2 cycles after en first rises.
- Square wave:
  - HIGH: counter decrements each cycle. At 0 -> LOW, pin_out=0, counter loads max(LOW_CYC,1)-1.
  - LOW: mirror of HIGH; at 0 -> HIGH, pin_out=1.
  - Zero counts are clamped to 1, so the minimum period is 2 cycles.
- Stop time:
  - If END_TIME!=0 and current_time >= END_TIME while in CONST/HIGH/LOW -> IDLE next cycle, pin_oe=0.
  - END_TIME==0 runs indefinitely.
  - END_TIME is sampled continuously; an END_TIME already in the past stops the run 1 cycle after entry.
- busy: registered. 1 while state!=IDLE and END_TIME!=0; 0 otherwise. Drops the same cycle pin_oe drops.
- Simultaneous events:
  - A CMD accept in the same cycle as stop-time expiry: the CMD wins.
  - A CMD during a running wave restarts immediately in the new mode; the counter reloads.
  - Writes to HIGH_CYC or LOW_CYC mid-wave take effect at the next phase reload.
- Arithmetic: 32-bit unsigned comparisons. The timer wrap from 32'hFFFFFFFF to 0 is not special-cased; a run armed near wrap stops only when current_time >= END_TIME again.
- Mid-operation reset returns everything to the reset values asynchronously. The first bus write after rst release is accepted normally.

Test Plan:
- Reset with en=1 held -> pin_oe=0, pin_out=0, busy=0. Deassert rst with a matching write present -> write accepted exactly once.
- Write HIGH_CYC=3, LOW_CYC=2, END_TIME=0, then CMD=2 (each held 2 cycles) -> pin high 3 cycles, low 2, period 5, repeating; busy stays 0.
- END_TIME=100, CMD=1 with data[2]=1 at time 50 -> pin_oe=1, pin_out=1, busy=1. At current_time=100 -> next cycle pin_oe=0, busy=0.
- HIGH_CYC=0, LOW_CYC=0, CMD=2 -> pin toggles every cycle (period 2).
- Write to BASE_ADDR+1 unit address, or with rd=1 and wr=0 -> no register change and no pin activity. A CMD held 2 cycles yields a single start, with no counter reload on the second cycle.
- CMD=3 during a running wave -> next cycle pin_oe=0, state holds. CMD=2 written in the stop-time cycle -> wave restarts and busy stays 1.
